led_act_drv: RTL

Generates the run-time LED patterns that the power-up LED sequencer forwards to the panel once boot completes. Drives two LEDs per direction: a steady link/enable LED and a stretched, rate-limited activity LED. Adds a fault-blink override on the link LEDs. Sits between the optical link datapath, where activity strobes originate, and the boot-time LED override stage, whose run-time LED inputs it feeds.

---
 rtl/led_act_drv.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/led_act_drv.sv
// Run-time panel LED driver: steady link/enable LEDs with a fault-blink override,
// plus stretched, rate-limited activity LEDs for the receive and transmit directions.
module led_act_drv #(
  parameter int unsigned ON_CLKS         = 1200000,
  parameter int unsigned OFF_CLKS        = 1200000,
  parameter int unsigned FAULT_HALF_CLKS = 10000000
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_boot_done,
  input  logic       i_rx_sig_det,
  input  logic       i_rx_act,
  input  logic       i_tx_en,
  input  logic       i_tx_act,
  input  logic       i_fault,
  output logic [1:0] o_rx_led,
  output logic [1:0] o_tx_led
);

  localparam logic [23:0] ON_LAST   = 24'(ON_CLKS - 1);
  localparam logic [23:0] OFF_LAST  = 24'(OFF_CLKS - 1);
  localparam logic [23:0] HALF_LAST = 24'(FAULT_HALF_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } act_state_e;

  logic        sig_meta_q;
  logic        sig_sync_q;
  logic        rx_link_q;
  logic        tx_link_q;
  logic        fault_act_q;
  logic        fault_phase_q;
  logic [23:0] fault_cnt_q;
  logic        fault_phase_d;
  logic [23:0] fault_cnt_d;
  logic        fault_cur_phase;
  logic        fault_wrap;
  logic [1:0]  act_in;
  logic [1:0]  act_led;

  // Signal detect is an asynchronous pin; the synchronizer runs even while boot is pending.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sig_meta_q <= 1'b0;
      sig_sync_q <= 1'b0;
    end else begin
      sig_meta_q <= i_rx_sig_det;
      sig_sync_q <= sig_meta_q;
    end
  end

  // On the first fault cycle the blink starts from phase 1 with a fresh count.
  always_comb begin
    fault_cur_phase = fault_act_q ? fault_phase_q : 1'b1;
    fault_cnt_d     = fault_act_q ? fault_cnt_q : 24'd0;
    fault_wrap      = (fault_cnt_d == HALF_LAST);
    fault_phase_d   = fault_wrap ? ~fault_cur_phase : fault_cur_phase;
    if (fault_wrap) begin
      fault_cnt_d = 24'd0;
    end else begin
      fault_cnt_d = fault_cnt_d + 24'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      fault_act_q   <= 1'b0;
      fault_phase_q <= 1'b0;
      fault_cnt_q   <= 24'd0;
    end else if (!i_boot_done || !i_fault) begin
      fault_act_q   <= 1'b0;
      fault_phase_q <= 1'b0;
      fault_cnt_q   <= 24'd0;
    end else begin
      fault_act_q   <= 1'b1;
      fault_phase_q <= fault_phase_d;
      fault_cnt_q   <= fault_cnt_d;
    end
  end

  // Fault blink overrides both link/enable LEDs, taking priority over any link change.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      rx_link_q <= 1'b0;
      tx_link_q <= 1'b0;
    end else if (!i_boot_done) begin
      rx_link_q <= 1'b0;
      tx_link_q <= 1'b0;
    end else begin
      rx_link_q <= i_fault ? fault_cur_phase : sig_sync_q;
      tx_link_q <= i_fault ? fault_cur_phase : i_tx_en;
    end
  end

  assign act_in = {i_tx_act, i_rx_act};

  for (genvar gi = 0; gi < 2; gi++) begin : g_act
    act_state_e  state_q;
    logic [23:0] cnt_q;
    logic        pend_q;
    logic        led_q;

    // The LED register is loaded with (next state == ON), so it tracks the state without lag.
    always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= 24'd0;
        pend_q  <= 1'b0;
        led_q   <= 1'b0;
      end else if (!i_boot_done) begin
        state_q <= ST_IDLE;
        cnt_q   <= 24'd0;
        pend_q  <= 1'b0;
        led_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (act_in[gi]) begin
              state_q <= ST_ON;
              cnt_q   <= 24'd0;
              led_q   <= 1'b1;
            end else begin
              led_q   <= 1'b0;
            end
          end
          ST_ON: begin
            if (cnt_q == ON_LAST) begin
              state_q <= ST_OFF;
              cnt_q   <= 24'd0;
              pend_q  <= 1'b0;
              led_q   <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + 24'd1;
              led_q   <= 1'b1;
            end
          end
          ST_OFF: begin
            if (cnt_q == OFF_LAST) begin
              cnt_q  <= 24'd0;
              pend_q <= 1'b0;
              if (pend_q || act_in[gi]) begin
                state_q <= ST_ON;
                led_q   <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                led_q   <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 24'd1;
              led_q <= 1'b0;
              if (act_in[gi]) begin
                pend_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= 24'd0;
            pend_q  <= 1'b0;
            led_q   <= 1'b0;
          end
        endcase
      end
    end

    assign act_led[gi] = led_q;
  end

  assign o_rx_led = {act_led[0], rx_link_q};
  assign o_tx_led = {act_led[1], tx_link_q};

endmodule
